// File: rtl/ibex_wb_queue_if.sv
// Handshake bundle between ID/EX + LSU (master side) and the writeback queue (slave side).
interface ibex_wb_queue_if #(
  parameter int Depth = 2
);
  localparam int CntW = $clog2(Depth + 1);

  logic            en_wb_i;
  logic [1:0]      instr_type_wb_i;
  logic [31:0]     pc_id_i;
  logic            instr_is_compressed_id_i;
  logic            instr_perf_count_id_i;
  logic [4:0]      rf_waddr_id_i;
  logic [31:0]     rf_wdata_id_i;
  logic            rf_we_id_i;
  logic            lsu_resp_valid_i;
  logic            lsu_resp_err_i;
  logic [31:0]     rf_wdata_lsu_i;
  logic [4:0]      rf_raddr_a_i;
  logic [4:0]      rf_raddr_b_i;
  logic            ready_wb_o;
  logic [CntW-1:0] occupancy_o;
  logic            rf_we_wb_o;
  logic [4:0]      rf_waddr_wb_o;
  logic [31:0]     rf_wdata_wb_o;
  logic            hazard_a_o;
  logic            hazard_b_o;
  logic            outstanding_load_wb_o;
  logic            outstanding_store_wb_o;
  logic            instr_done_wb_o;
  logic [31:0]     pc_wb_o;
  logic            perf_instr_ret_wb_o;
  logic            perf_instr_ret_compressed_wb_o;
  logic            resp_unexpected_o;

  modport master (
    output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, lsu_resp_valid_i, lsu_resp_err_i,
           rf_wdata_lsu_i, rf_raddr_a_i, rf_raddr_b_i,
    input  ready_wb_o, occupancy_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, hazard_a_o,
           hazard_b_o, outstanding_load_wb_o, outstanding_store_wb_o, instr_done_wb_o, pc_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, resp_unexpected_o
  );

  modport slave (
    input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, lsu_resp_valid_i, lsu_resp_err_i,
           rf_wdata_lsu_i, rf_raddr_a_i, rf_raddr_b_i,
    output ready_wb_o, occupancy_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, hazard_a_o,
           hazard_b_o, outstanding_load_wb_o, outstanding_store_wb_o, instr_done_wb_o, pc_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, resp_unexpected_o
  );
endinterface

// File: rtl/ibex_wb_queue.sv
// In-order writeback queue: instructions retire from the head once their LSU response
// (if any) has been seen; responses bind to the oldest memory entry still waiting.
module ibex_wb_queue #(
  parameter int Depth    = 2,
  parameter bit ResetAll = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ibex_wb_queue_if.slave wb
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt   = CntW'(Depth);
  localparam logic [1:0]      TypeLoad  = 2'd0;
  localparam logic [1:0]      TypeStore = 2'd1;

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] pc;
    logic        comp;
    logic        perf;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } entry_t;

  logic [Depth-1:0] valid_q, seen_q;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;
  entry_t           ent_q [Depth];
  entry_t           ent_d [Depth];

  logic            tgt_found, resp_hit, resp_head;
  logic [PtrW-1:0] tgt_idx, idx;
  logic            head_valid, head_is_mem, head_is_load, head_done, head_err, ready, enq;
  int              k;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Walk from youngest to oldest so the oldest waiting memory entry wins.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = '0;
    idx       = '0;
    k         = 0;
    for (int i = Depth - 1; i >= 0; i--) begin
      k = int'(head_q) + i;
      if (k >= Depth) k = k - Depth;
      idx = PtrW'(k);
      if (valid_q[idx] && !seen_q[idx] &&
          (ent_q[idx].typ == TypeLoad || ent_q[idx].typ == TypeStore)) begin
        tgt_found = 1'b1;
        tgt_idx   = idx;
      end
    end
  end

  assign resp_hit     = wb.lsu_resp_valid_i & tgt_found;
  assign resp_head    = resp_hit & (tgt_idx == head_q);
  assign head_valid   = valid_q[head_q];
  assign head_is_load = ent_q[head_q].typ == TypeLoad;
  assign head_is_mem  = head_is_load | (ent_q[head_q].typ == TypeStore);
  assign head_done    = head_valid & (~head_is_mem | seen_q[head_q] | resp_head);
  assign head_err     = seen_q[head_q] ? ent_q[head_q].err : (resp_head & wb.lsu_resp_err_i);
  assign ready        = (count_q < FullCnt) | head_done;
  assign enq          = wb.en_wb_i & ready;

  assign wb.ready_wb_o      = ready;
  assign wb.occupancy_o     = count_q;
  assign wb.instr_done_wb_o = head_done;
  assign wb.rf_we_wb_o      = head_done & (head_is_mem ? (head_is_load & ~head_err)
                                                       : ent_q[head_q].we);
  assign wb.rf_waddr_wb_o   = head_done ? ent_q[head_q].waddr : '0;
  // A load retiring in its response cycle forwards the LSU data straight through.
  assign wb.rf_wdata_wb_o   = !head_done ? '0 :
                              (head_is_load & resp_head) ? wb.rf_wdata_lsu_i : ent_q[head_q].wdata;
  assign wb.pc_wb_o                        = head_valid ? ent_q[head_q].pc : '0;
  assign wb.perf_instr_ret_wb_o            = head_done & ent_q[head_q].perf & ~head_err;
  assign wb.perf_instr_ret_compressed_wb_o = wb.perf_instr_ret_wb_o & ent_q[head_q].comp;
  assign wb.resp_unexpected_o              = wb.lsu_resp_valid_i & ~tgt_found & ~rst_i;

  always_comb begin
    wb.hazard_a_o             = 1'b0;
    wb.hazard_b_o             = 1'b0;
    wb.outstanding_load_wb_o  = 1'b0;
    wb.outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i]) begin
        if (ent_q[i].we || ent_q[i].typ == TypeLoad) begin
          if (wb.rf_raddr_a_i != 5'd0 && ent_q[i].waddr == wb.rf_raddr_a_i) wb.hazard_a_o = 1'b1;
          if (wb.rf_raddr_b_i != 5'd0 && ent_q[i].waddr == wb.rf_raddr_b_i) wb.hazard_b_o = 1'b1;
        end
        if (!seen_q[i] && ent_q[i].typ == TypeLoad)  wb.outstanding_load_wb_o  = 1'b1;
        if (!seen_q[i] && ent_q[i].typ == TypeStore) wb.outstanding_store_wb_o = 1'b1;
      end
    end
  end

  // Control state; enqueue is applied last so a full queue can refill the retiring slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      seen_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (resp_hit) seen_q[tgt_idx] <= 1'b1;
      if (head_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        seen_q[tail_q]  <= 1'b0;
        tail_q          <= ptr_inc(tail_q);
      end
      if (enq && !head_done)      count_q <= count_q + 1'b1;
      else if (!enq && head_done) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (resp_hit) begin
      ent_d[tgt_idx].err = wb.lsu_resp_err_i;
      if (ent_q[tgt_idx].typ == TypeLoad) ent_d[tgt_idx].wdata = wb.rf_wdata_lsu_i;
    end
    if (enq) begin
      ent_d[tail_q] = '{typ: wb.instr_type_wb_i, pc: wb.pc_id_i,
                        comp: wb.instr_is_compressed_id_i, perf: wb.instr_perf_count_id_i,
                        we: wb.rf_we_id_i, waddr: wb.rf_waddr_id_i, wdata: wb.rf_wdata_id_i,
                        err: 1'b0};
    end
  end

  if (ResetAll) begin : g_payload_rst
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end
  end else begin : g_payload
    always_ff @(posedge clk_i) begin
      ent_q <= ent_d;
    end
  end
endmodule

// File: tb/tb_ibex_wb_queue.sv
// Bench for ibex_wb_queue: directed vector table, randomized traffic against a queue model,
// and an asynchronous reset in the middle of an outstanding load.
module tb_ibex_wb_queue;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ibex_wb_queue_if #(.Depth(DEPTH)) bus ();
  ibex_wb_queue #(.Depth(DEPTH), .ResetAll(1'b0)) dut (.clk_i(clk), .rst_i(rst), .wb(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit en; logic [1:0] typ; logic [4:0] wa; logic [31:0] wd; bit we;
    bit rv; bit re; logic [31:0] rd; logic [4:0] ra; logic [4:0] rb;
    bit x_ready; logic [3:0] x_occ; bit x_done; bit x_we; logic [4:0] x_wa; logic [31:0] x_wd;
    bit x_perf; bit x_ha; bit x_hb; bit x_unexp;
  } vec_t;

  typedef struct {
    logic [1:0] typ; logic [31:0] pc; bit comp; bit perf; bit we;
    logic [4:0] waddr; logic [31:0] wdata; bit seen; bit err;
  } ent_t;

  vec_t tbl [16];
  ent_t mq [$];

  bit e_ready, e_done, e_we, e_perf, e_comp, e_ha, e_hb, e_ol, e_os, e_unexp, e_hit;
  int e_occ, e_tgt;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_pc;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input bit en, input logic [1:0] typ, input logic [4:0] wa,
                       input logic [31:0] wd, input bit we, input bit rv, input bit re,
                       input logic [31:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] pc, input bit comp, input bit perf);
    bus.en_wb_i = en;              bus.instr_type_wb_i = typ;
    bus.rf_waddr_id_i = wa;        bus.rf_wdata_id_i = wd;        bus.rf_we_id_i = we;
    bus.lsu_resp_valid_i = rv;     bus.lsu_resp_err_i = re;       bus.rf_wdata_lsu_i = rd;
    bus.rf_raddr_a_i = ra;         bus.rf_raddr_b_i = rb;         bus.pc_id_i = pc;
    bus.instr_is_compressed_id_i = comp;
    bus.instr_perf_count_id_i = perf;
  endtask

  task automatic idle();
    drive(0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Expected outputs from the queue contents and the current inputs.
  task automatic model_eval();
    bit err;
    e_tgt = -1;
    for (int j = 0; j < mq.size(); j++)
      if (e_tgt < 0 && mq[j].typ != 2'd2 && !mq[j].seen) e_tgt = j;
    e_hit   = bus.lsu_resp_valid_i && e_tgt >= 0;
    e_unexp = bus.lsu_resp_valid_i && e_tgt < 0;
    e_occ   = mq.size();
    e_done = 0; err = 0; e_we = 0; e_wa = 0; e_wd = 0; e_pc = 0; e_perf = 0; e_comp = 0;
    if (mq.size() > 0) begin
      e_pc   = mq[0].pc;
      e_done = mq[0].typ == 2'd2 || mq[0].seen || (e_hit && e_tgt == 0);
      err    = mq[0].seen ? mq[0].err : (e_hit && e_tgt == 0 && bus.lsu_resp_err_i);
      e_we   = e_done && ((mq[0].typ == 2'd2) ? mq[0].we : (mq[0].typ == 2'd0 && !err));
      e_wa   = mq[0].waddr;
      e_wd   = (mq[0].typ == 2'd0 && e_hit && e_tgt == 0) ? bus.rf_wdata_lsu_i : mq[0].wdata;
      e_perf = e_done && mq[0].perf && !err;
      e_comp = e_perf && mq[0].comp;
    end
    e_ready = (mq.size() < DEPTH) || e_done;
    e_ha = 0; e_hb = 0; e_ol = 0; e_os = 0;
    foreach (mq[j]) begin
      if (mq[j].we || mq[j].typ == 2'd0) begin
        if (bus.rf_raddr_a_i != 0 && mq[j].waddr == bus.rf_raddr_a_i) e_ha = 1;
        if (bus.rf_raddr_b_i != 0 && mq[j].waddr == bus.rf_raddr_b_i) e_hb = 1;
      end
      if (!mq[j].seen && mq[j].typ == 2'd0) e_ol = 1;
      if (!mq[j].seen && mq[j].typ == 2'd1) e_os = 1;
    end
  endtask

  task automatic model_commit();
    ent_t t;
    if (e_hit) begin
      t = mq[e_tgt];
      t.seen = 1;
      t.err  = bus.lsu_resp_err_i;
      if (t.typ == 2'd0) t.wdata = bus.rf_wdata_lsu_i;
      mq[e_tgt] = t;
    end
    if (e_done) void'(mq.pop_front());
    if (bus.en_wb_i && e_ready) begin
      t = '{typ: bus.instr_type_wb_i, pc: bus.pc_id_i, comp: bus.instr_is_compressed_id_i,
            perf: bus.instr_perf_count_id_i, we: bus.rf_we_id_i, waddr: bus.rf_waddr_id_i,
            wdata: bus.rf_wdata_id_i, seen: 0, err: 0};
      mq.push_back(t);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            en typ wa wd           we rv re rd          ra rb  rdy occ dn we wa wd           pf ha hb ux
    tbl[0]  = '{1, 2, 5, 32'hA5A5_0001, 1, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 0};
    tbl[1]  = '{0, 2, 0, 0,             0, 0, 0, 0,          5, 0,  1, 1, 1, 1, 5, 32'hA5A5_0001, 1, 1, 0, 0};
    tbl[2]  = '{1, 0, 3, 0,             0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 0};
    tbl[3]  = '{1, 2, 4, 32'h44,        1, 0, 0, 0,          3, 4,  1, 1, 0, 0, 0, 0,            0, 1, 0, 0};
    tbl[4]  = '{0, 2, 0, 0,             0, 0, 0, 0,          3, 4,  0, 2, 0, 0, 0, 0,            0, 1, 1, 0};
    tbl[5]  = '{1, 2, 6, 32'h66,        1, 1, 0, 32'h1234,   3, 6,  1, 2, 1, 1, 3, 32'h1234,     1, 1, 0, 0};
    tbl[6]  = '{0, 2, 0, 0,             0, 0, 0, 0,          0, 6,  1, 2, 1, 1, 4, 32'h44,       1, 0, 1, 0};
    tbl[7]  = '{0, 2, 0, 0,             0, 0, 0, 0,          0, 0,  1, 1, 1, 1, 6, 32'h66,       1, 0, 0, 0};
    tbl[8]  = '{0, 2, 0, 0,             0, 1, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 1};
    tbl[9]  = '{1, 0, 7, 0,             0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 0};
    tbl[10] = '{0, 2, 0, 0,             0, 1, 1, 32'hDEAD,   7, 0,  1, 1, 1, 0, 7, 0,            0, 1, 0, 0};
    tbl[11] = '{1, 1, 9, 0,             0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 0};
    tbl[12] = '{1, 2, 2, 32'h22,        1, 0, 0, 0,          9, 0,  1, 1, 0, 0, 0, 0,            0, 0, 0, 0};
    tbl[13] = '{0, 2, 0, 0,             0, 1, 0, 0,          2, 0,  1, 2, 1, 0, 9, 0,            1, 1, 0, 0};
    tbl[14] = '{0, 2, 0, 0,             0, 0, 0, 0,          0, 0,  1, 1, 1, 1, 2, 32'h22,       1, 0, 0, 0};
    tbl[15] = '{0, 2, 0, 0,             0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0, 0};

    idle();
    bus.lsu_resp_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 0, 32'(bus.ready_wb_o), 1);
    chk("rst_occ",   0, 32'(bus.occupancy_o), 0);
    chk("rst_we",    0, 32'(bus.rf_we_wb_o), 0);
    chk("rst_done",  0, 32'(bus.instr_done_wb_o), 0);
    chk("rst_pc",    0, bus.pc_wb_o, 0);
    chk("rst_unexp", 0, 32'(bus.resp_unexpected_o), 0);
    chk("rst_oload", 0, 32'(bus.outstanding_load_wb_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].en, tbl[r].typ, tbl[r].wa, tbl[r].wd, tbl[r].we, tbl[r].rv, tbl[r].re,
            tbl[r].rd, tbl[r].ra, tbl[r].rb, 32'h1000 + 32'(r * 4), 1'b0, 1'b1);
      @(negedge clk);
      chk("t_ready", r, 32'(bus.ready_wb_o), 32'(tbl[r].x_ready));
      chk("t_occ",   r, 32'(bus.occupancy_o), 32'(tbl[r].x_occ));
      chk("t_done",  r, 32'(bus.instr_done_wb_o), 32'(tbl[r].x_done));
      chk("t_we",    r, 32'(bus.rf_we_wb_o), 32'(tbl[r].x_we));
      chk("t_perf",  r, 32'(bus.perf_instr_ret_wb_o), 32'(tbl[r].x_perf));
      chk("t_haz_a", r, 32'(bus.hazard_a_o), 32'(tbl[r].x_ha));
      chk("t_haz_b", r, 32'(bus.hazard_b_o), 32'(tbl[r].x_hb));
      chk("t_unexp", r, 32'(bus.resp_unexpected_o), 32'(tbl[r].x_unexp));
      if (tbl[r].x_we) begin
        chk("t_waddr", r, 32'(bus.rf_waddr_wb_o), 32'(tbl[r].x_wa));
        chk("t_wdata", r, bus.rf_wdata_wb_o, tbl[r].x_wd);
      end
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
    end

    for (int c = 0; c < 500; c++) begin
      drive(bit'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 2)), 5'($urandom_range(0, 7)),
            $urandom, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 9) < 4),
            bit'($urandom_range(0, 9) < 2), $urandom, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom, bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
      @(negedge clk);
      model_eval();
      chk("r_ready", c, 32'(bus.ready_wb_o), 32'(e_ready));
      chk("r_occ",   c, 32'(bus.occupancy_o), 32'(e_occ));
      chk("r_done",  c, 32'(bus.instr_done_wb_o), 32'(e_done));
      chk("r_we",    c, 32'(bus.rf_we_wb_o), 32'(e_we));
      chk("r_pc",    c, bus.pc_wb_o, e_pc);
      chk("r_perf",  c, 32'(bus.perf_instr_ret_wb_o), 32'(e_perf));
      chk("r_comp",  c, 32'(bus.perf_instr_ret_compressed_wb_o), 32'(e_comp));
      chk("r_haz_a", c, 32'(bus.hazard_a_o), 32'(e_ha));
      chk("r_haz_b", c, 32'(bus.hazard_b_o), 32'(e_hb));
      chk("r_oload", c, 32'(bus.outstanding_load_wb_o), 32'(e_ol));
      chk("r_ostor", c, 32'(bus.outstanding_store_wb_o), 32'(e_os));
      chk("r_unexp", c, 32'(bus.resp_unexpected_o), 32'(e_unexp));
      if (e_done) chk("r_waddr", c, 32'(bus.rf_waddr_wb_o), 32'(e_wa));
      if (e_we)   chk("r_wdata", c, bus.rf_wdata_wb_o, e_wd);
      @(posedge clk);
      model_commit();
      #1;
    end

    // Asynchronous reset while a load to x7 is outstanding.
    idle();
    rst = 1'b1;
    #1 chk("m_rst_occ", 0, 32'(bus.occupancy_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    drive(1, 2'd0, 5'd7, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 0, 1);
    @(posedge clk);
    #1 idle();
    bus.rf_raddr_a_i = 5'd7;
    #2;
    chk("m_haz_a", 0, 32'(bus.hazard_a_o), 1);
    chk("m_haz_b", 0, 32'(bus.hazard_b_o), 0);
    chk("m_oload", 0, 32'(bus.outstanding_load_wb_o), 1);
    chk("m_occ",   0, 32'(bus.occupancy_o), 1);
    rst = 1'b1;
    #1;
    chk("m_rst_haz_a", 0, 32'(bus.hazard_a_o), 0);
    chk("m_rst_oload", 0, 32'(bus.outstanding_load_wb_o), 0);
    chk("m_rst_occ",   1, 32'(bus.occupancy_o), 0);
    chk("m_rst_ready", 0, 32'(bus.ready_wb_o), 1);
    chk("m_rst_pc",    0, bus.pc_wb_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.lsu_resp_valid_i = 1'b1;
    bus.rf_wdata_lsu_i   = 32'h0BAD;
    #2;
    chk("m_unexp", 0, 32'(bus.resp_unexpected_o), 1);
    chk("m_done",  0, 32'(bus.instr_done_wb_o), 0);
    @(posedge clk);
    #1 bus.lsu_resp_valid_i = 1'b0;
    #2;
    chk("m_unexp", 1, 32'(bus.resp_unexpected_o), 0);
    chk("m_occ_end", 0, 32'(bus.occupancy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
